// File: rtl/seq_detector_par_if.sv
// Bundle of the control, input-word and result signals of seq_detector_par.
// Handshake: there is no ready. The detector accepts every word presented with
// in_valid=1 unless clear or reset is active in that cycle. It answers one cycle
// later with out_valid=1 for exactly one cycle per accepted word.
interface seq_detector_par_if #(
    parameter int LANES = 8,
    parameter int CNT_W = 16
);
    logic             clear;
    logic             overlap_en;
    logic             in_valid;
    logic [LANES-1:0] in_data;
    logic             out_valid;
    logic [LANES-1:0] match;
    logic [CNT_W-1:0] match_cnt;

    // Bit-stream source side
    modport master (
        output clear, overlap_en, in_valid, in_data,
        input  out_valid, match, match_cnt
    );

    // Detector side
    modport slave (
        input  clear, overlap_en, in_valid, in_data,
        output out_valid, match, match_cnt
    );
endinterface

// File: rtl/seq_detector_par.sv
// Parallel serial-pattern detector. Every accepted LANES-bit word is scanned
// MSB first. match[i] flags the bit where the last PAT_LEN bits equal PATTERN.
// History carries across words and idle cycles. Results are registered, so the
// latency is one cycle.
// Optional feature macro SEQ_DET_CNT_EN: when it is defined, a saturating match
// counter drives match_cnt. When it is undefined, match_cnt is tied to 0.
module seq_detector_par #(
    parameter int                 LANES   = 8,
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter int                 CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_detector_par_if.slave  bus
);
    localparam int FILL_W = $clog2(PAT_LEN) + 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_out_valid;
    logic [LANES-1:0]   r_match;

    logic [PAT_LEN-2:0] w_hist;
    logic [FILL_W-1:0]  w_fill;
    logic [PAT_LEN-1:0] w_win;
    logic [LANES-1:0]   w_match;
    logic               w_hit;

    // Walk the word from its earliest bit. A non-overlapping hit empties fill,
    // so the stale history bits can never contribute to the next match.
    always_comb begin
        w_hist  = r_hist;
        w_fill  = r_fill;
        w_win   = '0;
        w_hit   = 1'b0;
        w_match = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            w_win      = {w_hist, bus.in_data[i]};
            w_hit      = (w_fill >= FILL_MAX) && (w_win == PATTERN);
            w_match[i] = w_hit;
            w_hist     = w_win[PAT_LEN-2:0];
            if (w_hit && !bus.overlap_en) begin
                w_fill = '0;
            end else if (w_fill < FILL_MAX) begin
                w_fill = w_fill + FILL_W'(1);
            end
        end
    end

    // History, fill and registered results. Reset beats clear, and clear beats
    // a word presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            r_hist      <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_match     <= '0;
        end else if (bus.in_valid) begin
            r_hist      <= w_hist;
            r_fill      <= w_fill;
            r_out_valid <= 1'b1;
            r_match     <= w_match;
        end else begin
            r_out_valid <= 1'b0;
            r_match     <= '0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.match     = r_match;

`ifdef SEQ_DET_CNT_EN
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  w_pop;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    // Add this word's hits to the running total, and pin the total at all-ones
    // instead of letting it wrap.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + PC_W'(w_match[i]);
        end
        w_sum = SUM_W'(r_cnt) + SUM_W'(w_pop);
        if (w_sum > SUM_W'({CNT_W{1'b1}})) begin
            w_cnt_next = '1;
        end else begin
            w_cnt_next = w_sum[CNT_W-1:0];
        end
    end

    // The counter is updated on the same edge that registers match.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            r_cnt <= '0;
        end else if (bus.in_valid) begin
            r_cnt <= w_cnt_next;
        end
    end

    assign bus.match_cnt = r_cnt;
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_par.sv
// Bench for seq_detector_par. A bit-queue reference model predicts every output
// cycle into an expected queue. One negedge process compares the DUT with that
// queue. Directed cases pin the model to hand-worked literals. A second instance
// with CNT_W=2 covers counter saturation.
module tb_seq_detector_par;
    localparam int LANES   = 8;
    localparam int PAT_LEN = 3;
    localparam logic [PAT_LEN-1:0] PATTERN = 3'b101;
    localparam int CNT_W   = 16;
    localparam int EW      = 1 + CNT_W + LANES;
`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_detector_par_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();
    seq_detector_par_if #(.LANES(LANES), .CNT_W(2))     sbus ();

    seq_detector_par #(
        .LANES(LANES), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    seq_detector_par #(
        .LANES(LANES), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    bit              model_q[$];
    longint          model_cnt = 0;
    logic [EW-1:0]   exp_q[$];

    task automatic model_step(input logic v, input logic [LANES-1:0] d,
                              input logic ov, input logic clr, input logic rn);
        logic [LANES-1:0] m;
        int               val;
        int               pop;
        m   = '0;
        pop = 0;
        if (!rn || clr) begin
            model_q.delete();
            model_cnt = 0;
            exp_q.push_back('0);
        end else if (v) begin
            for (int i = LANES - 1; i >= 0; i--) begin
                model_q.push_back(d[i]);
                if (model_q.size() > PAT_LEN) void'(model_q.pop_front());
                val = 0;
                foreach (model_q[k]) val = val * 2 + int'(model_q[k]);
                if (model_q.size() == PAT_LEN && val == int'(PATTERN)) begin
                    m[i] = 1'b1;
                    pop++;
                    if (!ov) model_q.delete();
                end
            end
            model_cnt = model_cnt + pop;
            if (model_cnt > (64'd1 << CNT_W) - 1) model_cnt = (64'd1 << CNT_W) - 1;
            exp_q.push_back({1'b1, (CNT_ON ? CNT_W'(model_cnt) : CNT_W'(0)), m});
        end else begin
            exp_q.push_back({1'b0, (CNT_ON ? CNT_W'(model_cnt) : CNT_W'(0)), LANES'(0)});
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [LANES-1:0] d,
                        input logic ov, input logic clr, input logic rn);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.overlap_en = ov;
        bus.clear      = clr;
        rst_n          = rn;
        @(posedge clk);
        model_step(v, d, ov, clr, rn);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== e[EW-1]) begin
                n_errors++;
                $display("FAIL sb_out_valid @%0t: got %b expected %b", $time, bus.out_valid, e[EW-1]);
            end
            n_checks++;
            if (bus.match !== e[LANES-1:0]) begin
                n_errors++;
                $display("FAIL sb_match @%0t: got %b expected %b", $time, bus.match, e[LANES-1:0]);
            end
            n_checks++;
            if (bus.match_cnt !== e[EW-2:LANES]) begin
                n_errors++;
                $display("FAIL sb_match_cnt @%0t: got %0d expected %0d", $time, bus.match_cnt, e[EW-2:LANES]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.overlap_en = 1'b1; bus.clear = 1'b0;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.overlap_en = 1'b1; sbus.clear = 1'b0;
        rst_n = 1'b0;

        // reset state
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_match",     32'(bus.match),     32'd0);
        chk("rst_match_cnt", 32'(bus.match_cnt), 32'd0);

        // 1: overlapping and non-overlapping on the same word
        step(1'b1, 8'b1010_1000, 1'b1, 1'b0, 1'b1);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_match",     32'(bus.match),     32'b0010_1000);
        chk("t1_cnt",       32'(bus.match_cnt), CNT_ON ? 32'd2 : 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'b1010_1000, 1'b0, 1'b0, 1'b1);
        chk("t1n_match", 32'(bus.match),     32'b0010_0000);
        chk("t1n_cnt",   32'(bus.match_cnt), CNT_ON ? 32'd1 : 32'd0);

        // 2: cross-word match, back-to-back and with idle gap
        step(1'b1, 8'b0000_0010, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'b1000_0000, 1'b1, 1'b0, 1'b1);
        chk("t2_match", 32'(bus.match), 32'b1000_0000);
        step(1'b1, 8'b0000_0010, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
            chk("t2_idle_valid", 32'(bus.out_valid), 32'd0);
            chk("t2_idle_match", 32'(bus.match),     32'd0);
        end
        step(1'b1, 8'b1000_0000, 1'b1, 1'b0, 1'b1);
        chk("t2g_match", 32'(bus.match), 32'b1000_0000);

        // 3: reset mid-stream breaks the cross-word match
        step(1'b1, 8'b0000_0010, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'b1000_0000, 1'b1, 1'b0, 1'b1);
        chk("t3_match", 32'(bus.match),     32'd0);
        chk("t3_cnt",   32'(bus.match_cnt), 32'd0);

        // 4: clear with a valid word discards it and the history
        step(1'b1, 8'b1010_1010, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'b1010_1010, 1'b1, 1'b1, 1'b1);
        chk("t4_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_match", 32'(bus.match),     32'd0);
        chk("t4_cnt",   32'(bus.match_cnt), 32'd0);
        step(1'b1, 8'b0000_0001, 1'b1, 1'b0, 1'b1);
        chk("t4b_match", 32'(bus.match), 32'd0);

        // 5: saturation on the CNT_W=2 instance
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        sbus.in_valid = 1'b1; sbus.in_data = 8'b1010_1010; sbus.overlap_en = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("t5_match", 32'(sbus.match),     32'b0010_1010);
        chk("t5_cnt",   32'(sbus.match_cnt), CNT_ON ? 32'd3 : 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("t5b_match", 32'(sbus.match),     32'b1010_1010);
        chk("t5b_cnt",   32'(sbus.match_cnt), CNT_ON ? 32'd3 : 32'd0);
        sbus.in_valid = 1'b0;

        // randomized stream against the model
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 3) != 0),
                 LANES'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 150) != 0));
        end

        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
